// File: rtl/dec_3to8_if.sv
// Select-bus bundle for the 3-to-8 decoder: index/enable/clear in, decoded lines and coverage out.
// The master drives the index side; the decoder sits on the slave modport.
interface dec_3to8_if;
  logic [2:0] i;
  logic       en;
  logic       seen_clr;
  logic [7:0] y;
  logic [7:0] y_q;
  logic [7:0] seen;
  logic       all_seen;

  modport master (
    output i, en, seen_clr,
    input  y, y_q, seen, all_seen
  );

  modport slave (
    input  i, en, seen_clr,
    output y, y_q, seen, all_seen
  );
endinterface

// File: rtl/dec_3to8.sv
// 3-to-8 decoder: combinational one-hot output, registered copy, and a sticky coverage mask
// recording which lines have been selected since reset or the last clear.
module dec_3to8 #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  dec_3to8_if.slave   bus
);

  // Idle pattern of y/y_q: no line selected in the configured polarity.
  localparam logic [7:0] INACTIVE = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [7:0] w_d;
  logic [7:0] w_y;
  logic [7:0] r_y_q;
  logic [7:0] r_seen;

  always_comb begin
    w_d = 8'h00;
    if (bus.en) w_d = 8'h01 << bus.i;
  end

  assign w_y = ACTIVE_LOW ? ~w_d : w_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_q  <= INACTIVE;
      r_seen <= 8'h00;
    end else begin
      r_y_q <= w_y;
      // A clear still captures this cycle's selection so it is never lost.
      if (bus.seen_clr) r_seen <= w_d;
      else              r_seen <= r_seen | w_d;
    end
  end

  assign bus.y        = w_y;
  assign bus.y_q      = r_y_q;
  assign bus.seen     = r_seen;
  assign bus.all_seen = &r_seen;

endmodule

// File: tb/tb_dec_3to8.sv
// Directed bench for dec_3to8: one active-high and one active-low instance driven with the
// same stimulus, expected values written out by hand.
module tb_dec_3to8;

  logic clk;
  logic rst;

  dec_3to8_if bus0 ();
  dec_3to8_if bus1 ();

  dec_3to8 #(.ACTIVE_LOW(1'b0)) u_hi (.clk(clk), .rst(rst), .bus(bus0));
  dec_3to8 #(.ACTIVE_LOW(1'b1)) u_lo (.clk(clk), .rst(rst), .bus(bus1));

  int n_cmp;
  int n_bad;

  logic [7:0] onehot_tab [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic [2:0] idx, input logic e, input logic clr);
    bus0.i = idx; bus0.en = e; bus0.seen_clr = clr;
    bus1.i = idx; bus1.en = e; bus1.seen_clr = clr;
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    drive(3'd0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    drive(3'd3, 1'b1, 1'b0);
    rst = 1'b1;
    #2;
    chk8("reset_yq_hi", bus0.y_q, 8'h00);
    chk8("reset_seen", bus0.seen, 8'h00);
    chk1("reset_all_seen", bus0.all_seen, 1'b0);
    chk8("reset_yq_lo", bus1.y_q, 8'hFF);
    chk8("reset_y_follows", bus0.y, 8'h08);
    step();
    chk8("reset_held_yq", bus0.y_q, 8'h00);
    chk8("reset_held_seen", bus0.seen, 8'h00);
    drive(3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
  endtask

  task automatic test_sweep();
    for (int k = 0; k < 8; k++) begin
      drive(3'(k), 1'b1, 1'b0);
      #1;
      chk8($sformatf("sweep_y_%0d", k), bus0.y, onehot_tab[k]);
      step();
      chk8($sformatf("sweep_yq_%0d", k), bus0.y_q, onehot_tab[k]);
      if (k < 7) chk1($sformatf("sweep_not_all_%0d", k), bus0.all_seen, 1'b0);
    end
    chk8("sweep_seen", bus0.seen, 8'hFF);
    chk1("sweep_all_seen", bus0.all_seen, 1'b1);
  endtask

  task automatic test_enable_low();
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      drive(3'(k), 1'b0, 1'b0);
      #1;
      chk8($sformatf("dis_y_%0d", k), bus0.y, 8'h00);
      step();
      chk8($sformatf("dis_yq_%0d", k), bus0.y_q, 8'h00);
      chk8($sformatf("dis_seen_%0d", k), bus0.seen, 8'h00);
    end
  endtask

  task automatic test_polarity();
    drive(3'd3, 1'b1, 1'b0);
    #1;
    chk8("pol_y_sel3", bus1.y, 8'hF7);
    step();
    chk8("pol_yq_sel3", bus1.y_q, 8'hF7);
    chk8("pol_seen_sel3", bus1.seen, 8'h08);
    drive(3'd3, 1'b0, 1'b0);
    #1;
    chk8("pol_y_dis", bus1.y, 8'hFF);
    step();
    chk8("pol_yq_dis", bus1.y_q, 8'hFF);
  endtask

  task automatic test_clear();
    apply_reset();
    test_sweep();
    drive(3'd5, 1'b1, 1'b1);
    step();
    chk8("clr_seen", bus0.seen, 8'h20);
    chk1("clr_all_seen", bus0.all_seen, 1'b0);
    drive(3'd2, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk8($sformatf("clr_hold_%0d", c), bus0.seen, 8'h20);
    end
    drive(3'd1, 1'b1, 1'b0);
    step();
    chk8("clr_accum", bus0.seen, 8'h22);
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      drive(3'(k), 1'b1, 1'b0);
      step();
    end
    chk8("ar_pre_seen", bus0.seen, 8'h0F);
    drive(3'd6, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk8("ar_seen", bus0.seen, 8'h00);
    chk1("ar_all_seen", bus0.all_seen, 1'b0);
    chk8("ar_yq", bus0.y_q, 8'h00);
    chk8("ar_y_tracks", bus0.y, 8'h40);
    drive(3'd2, 1'b1, 1'b0);
    #1;
    chk8("ar_y_tracks2", bus0.y, 8'h04);
    step();
    rst = 1'b0;
    drive(3'd1, 1'b1, 1'b0);
    step();
    chk8("ar_resume_seen", bus0.seen, 8'h02);
    chk8("ar_resume_yq", bus0.y_q, 8'h02);
    drive(3'd4, 1'b1, 1'b0);
    step();
    chk8("ar_resume_seen2", bus0.seen, 8'h12);
  endtask

  task automatic test_reset_beats_clear();
    drive(3'd7, 1'b1, 1'b1);
    rst = 1'b1;
    step();
    chk8("rbc_seen", bus0.seen, 8'h00);
    chk8("rbc_yq", bus0.y_q, 8'h00);
    chk8("rbc_y", bus0.y, 8'h80);
    rst = 1'b0;
    step();
    chk8("rbc_after_seen", bus0.seen, 8'h80);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    drive(3'd6, 1'b1, 1'b0); step();
    chk8("b2b_yq_6", bus0.y_q, 8'h40);
    drive(3'd0, 1'b1, 1'b0); step();
    chk8("b2b_yq_0", bus0.y_q, 8'h01);
    drive(3'd6, 1'b0, 1'b0); step();
    chk8("b2b_yq_dis", bus0.y_q, 8'h00);
    chk8("b2b_seen", bus0.seen, 8'h41);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    onehot_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    rst = 1'b0;
    drive(3'd0, 1'b0, 1'b0);
    #2;
    test_reset();
    test_sweep();
    test_enable_low();
    test_polarity();
    test_clear();
    test_async_reset();
    test_reset_beats_clear();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
